obuf_bank_seq: RTL and testbench
================================

Name: obuf_bank_seq

Overview:
- Parametrised successor to the fixed 8-bit output-buffer wrapper.
- N-channel registered, tristate-capable output bank for stand test pins.
- Adds per-channel output enable, a write handshake, and sequenced output modes: static, timed pulse, walking-one and toggle.
- Sits between the stand control logic and the top-level pads, driving one OBUFT primitive per channel.

Parameters:
- WIDTH, 8, number of output channels.
- PULSE_W, 16, width of the pulse-length counter.
- DIV_W, 16, width of the step-rate divider.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- wr_valid  in  1  command valid.
- wr_ready  out  1  command accept; a transfer occurs when wr_valid and wr_ready are both 1.
- wr_mode  in  2  0 STATIC, 1 PULSE, 2 WALK, 3 TOGGLE.
- wr_data  in  WIDTH  output pattern.
- wr_oe  in  WIDTH  per-channel enable; 1 = drive, 0 = high-Z.
- pulse_len  in  PULSE_W  PULSE duration in cycles.
- div  in  DIV_W  WALK/TOGGLE step period, equal to div+1 cycles.
- busy  out  1  high while in PULSE.
- done  out  1  one-cycle strobe at the end of a PULSE.
- pad_o  out  WIDTH  to top-level pads via OBUFT.
- pad_t  out  WIDTH  internal tristate control; 1 = high-Z (OBUFT polarity).

Behaviour:
- Reset (async assert, sync release):
  - pad_o=0, pad_t=all 1, busy=0, done=0, wr_ready=0, state IDLE.
  - wr_ready rises on the first clock after rst_n deasserts.
  - Reset mid-operation aborts immediately to these values; no done strobe is issued.
- State machine states: IDLE, HOLD, PULSE, RUN.
- wr_ready=1 in IDLE, HOLD and RUN; 0 in PULSE.
- On an accepted write, all fields are latched (pulse_len, div, mode, data, oe).
- Output timing: pad_o and pad_t change on the clock after acceptance (1-cycle latency).
- pad_t = ~oe_reg at all times. A disabled channel still updates pad_o internally but stays high-Z.
- STATIC -> HOLD: pad_o=data; held until the next write.
- PULSE:
  - pad_o=data for max(pulse_len,1) cycles.
  - Then pad_o=0, done=1 for one cycle, state -> HOLD (oe kept).
  - busy=1 for exactly the pulse cycles.
- WALK -> RUN:
  - pad_o starts at bit 0 = 1, all other bits 0.
  - Rotates left every div+1 cycles; bit WIDTH-1 wraps to bit 0.
  - wr_data is ignored.
- TOGGLE -> RUN:
  - pad_o alternates between data and ~data every div+1 cycles, starting with data.
- div=0: step every cycle.
- Divider counter is cleared on each accepted write.
- Write accepted in RUN or HOLD: restarts immediately in the new mode; no glitch cycle.
- wr_valid held during PULSE: the write stalls and is accepted on the cycle done is asserted. The next state follows the new command.
- oe all zero: the sequence runs normally; all pads are high-Z.

Optional Feature:
- Macro: OBUF_BBM_EN (break-before-make).
- Defined:
  - Any accepted write whose wr_oe or first pattern differs from the current output inserts one cycle with pad_t=all 1 before the new values appear (latency 2).
  - wr_ready=0 during that cycle.
  - A PULSE still lasts the full pulse_len cycles after the gap.
- Undefined: latency 1, no gap.

Decomposition:
- Package obuf_bank_pkg:
  - mode constants MODE_STATIC/PULSE/WALK/TOGGLE (2-bit).
  - state enum encoding.
- Sub-module obuf_bank_pads:
  - generate loop of WIDTH OBUFT primitives (O to pads, I=pad_o, T=pad_t).
  - no logic in it.
- Top-level pads attach to obuf_bank_pads outputs only.

Test Plan:
- Reset with WIDTH=8 -> pad_t=8'hFF, pad_o=0; wr_ready=1 one cycle after rst_n rises.
- STATIC data=8'hA5, oe=8'h0F -> next cycle pad_o=A5, pad_t=F0; held 100 cycles.
- PULSE data=8'hFF, pulse_len=5 -> busy high 5 cycles, then pad_o=0, done single cycle; write held during busy is accepted on the done cycle.
- WALK div=2, oe=FF -> pad_o 01,02,04 … 80,01, each held 3 cycles; a new STATIC write mid-walk takes effect next cycle.
- TOGGLE data=8'h3C, div=0 -> pad_o 3C,C3,3C alternating every cycle; rst_n dropped mid-run -> outputs reset asynchronously the same cycle.
- OBUF_BBM_EN build, STATIC 8'h01 then 8'h02 -> one cycle pad_t=FF between them; total latency 2.

Source files
------------

// File: rtl/obuf_bank_pkg.sv
// Shared mode codes and FSM state encoding for the sequenced output bank.
// The ST_GAP state exists only when OBUF_BBM_EN (break-before-make) is defined.
package obuf_bank_pkg;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_PULSE  = 2'd1;
  localparam logic [1:0] MODE_WALK   = 2'd2;
  localparam logic [1:0] MODE_TOGGLE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_PULSE = 3'd2,
    ST_RUN   = 3'd3
`ifdef OBUF_BBM_EN
    ,
    ST_GAP   = 3'd4
`endif
  } state_e;

endpackage

// File: rtl/obuf_bank_pads.sv
// One OBUFT site per channel between the sequencer and the top-level pads.
// Outside synthesis each site is modelled as a straight wire.
module obuf_bank_pads #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] pad_i,
  input  logic [WIDTH-1:0] t_i,
  output logic [WIDTH-1:0] pad_o,
  output logic [WIDTH-1:0] pad_t_o
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
`ifdef SYNTHESIS
    OBUFT u_obuft (.O(pad_o[g]), .I(pad_i[g]), .T(t_i[g]));
`else
    assign pad_o[g] = pad_i[g];
`endif
    assign pad_t_o[g] = t_i[g];
  end

endmodule

// File: rtl/obuf_bank_seq.sv
// N-channel registered tristate output bank: static, timed pulse, walking-one and toggle.
// Optional break-before-make gap cycle: define OBUF_BBM_EN.
module obuf_bank_seq
  import obuf_bank_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PULSE_W = 16,
  parameter int DIV_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [1:0]         wr_mode,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic [WIDTH-1:0]   wr_oe,
  input  logic [PULSE_W-1:0] pulse_len,
  input  logic [DIV_W-1:0]   div,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   pad_o,
  output logic [WIDTH-1:0]   pad_t
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pat_q, pat_d;
  logic [WIDTH-1:0]   oe_q, oe_d;
  logic               done_q, done_d;
  logic               rdy_en_q;
  logic [1:0]         mode_q, mode_d;
  logic [DIV_W-1:0]   div_q, div_d, dcnt_q, dcnt_d;
  logic [PULSE_W-1:0] cnt_q, cnt_d;
`ifdef OBUF_BBM_EN
  logic [WIDTH-1:0]   data_q, data_d;
  logic [PULSE_W-1:0] len_q, len_d;
`endif

  logic               accept, launch;
  logic [1:0]         l_mode;
  logic [WIDTH-1:0]   l_data;
  logic [PULSE_W-1:0] l_len;
  logic [WIDTH-1:0]   pad_t_int;

  function automatic logic [WIDTH-1:0] first_pat(input logic [1:0] m, input logic [WIDTH-1:0] d);
    return (m == MODE_WALK) ? WIDTH'(1) : d;
  endfunction

  function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] v);
    return (v << 1) | (v >> (WIDTH - 1));
  endfunction

  // rdy_en_q holds wr_ready low until the first clock after reset release
`ifdef OBUF_BBM_EN
  assign wr_ready = rdy_en_q && (state_q != ST_PULSE) && (state_q != ST_GAP);
  assign pad_t_int = (state_q == ST_GAP) ? '1 : ~oe_q;
`else
  assign wr_ready = rdy_en_q && (state_q != ST_PULSE);
  assign pad_t_int = ~oe_q;
`endif
  assign accept = wr_valid && wr_ready;
  assign busy   = (state_q == ST_PULSE);
  assign done   = done_q;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    oe_d    = oe_q;
    mode_d  = mode_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    done_d  = 1'b0;
    launch  = 1'b0;
    l_mode  = wr_mode;
    l_data  = wr_data;
    l_len   = pulse_len;
`ifdef OBUF_BBM_EN
    data_d  = data_q;
    len_d   = len_q;
`endif
    case (state_q)
      ST_PULSE: begin
        if (cnt_q == '0) begin
          pat_d   = '0;
          done_d  = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (dcnt_q == div_q) begin
          dcnt_d = '0;
          pat_d  = (mode_q == MODE_WALK) ? rotl1(pat_q) : ~pat_q;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
`ifdef OBUF_BBM_EN
      ST_GAP: begin
        launch = 1'b1;
        l_mode = mode_q;
        l_data = data_q;
        l_len  = len_q;
      end
`endif
      default: ;
    endcase

    if (accept) begin
      oe_d   = wr_oe;
      mode_d = wr_mode;
      div_d  = div;
      dcnt_d = '0;
`ifdef OBUF_BBM_EN
      data_d = wr_data;
      len_d  = pulse_len;
      // Blank all pads for one cycle whenever what the pins show would change
      if ((wr_oe != oe_q) || (first_pat(wr_mode, wr_data) != pat_q))
        state_d = ST_GAP;
      else
        launch = 1'b1;
`else
      launch = 1'b1;
`endif
    end

    if (launch) begin
      pat_d  = first_pat(l_mode, l_data);
      dcnt_d = '0;
      cnt_d  = (l_len == '0) ? '0 : l_len - 1'b1;
      case (l_mode)
        MODE_STATIC: state_d = ST_HOLD;
        MODE_PULSE:  state_d = ST_PULSE;
        default:     state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pat_q    <= '0;
      oe_q     <= '0;
      done_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      oe_q     <= oe_d;
      done_q   <= done_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Command fields and counters are always (re)loaded before use, so need no reset
  always_ff @(posedge clk) begin
    mode_q <= mode_d;
    div_q  <= div_d;
    cnt_q  <= cnt_d;
    dcnt_q <= dcnt_d;
`ifdef OBUF_BBM_EN
    data_q <= data_d;
    len_q  <= len_d;
`endif
  end

  obuf_bank_pads #(.WIDTH(WIDTH)) u_pads (
    .pad_i   (pat_q),
    .t_i     (pad_t_int),
    .pad_o   (pad_o),
    .pad_t_o (pad_t)
  );

endmodule

// File: tb/tb_obuf_bank_seq.sv
// Directed self-checking bench for obuf_bank_seq (WIDTH=8); follows OBUF_BBM_EN if defined.
module tb_obuf_bank_seq;

`ifdef OBUF_BBM_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_mode;
  logic [7:0]  wr_data;
  logic [7:0]  wr_oe;
  logic [15:0] pulse_len;
  logic [15:0] div;
  logic        busy;
  logic        done;
  logic [7:0]  pad_o;
  logic [7:0]  pad_t;

  int n_chk;
  int n_fail;

  obuf_bank_seq #(.WIDTH(8), .PULSE_W(16), .DIV_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_mode   (wr_mode),
    .wr_data   (wr_data),
    .wr_oe     (wr_oe),
    .pulse_len (pulse_len),
    .div       (div),
    .busy      (busy),
    .done      (done),
    .pad_o     (pad_o),
    .pad_t     (pad_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one write; returns on the falling edge where the new values should be visible
  task automatic wr(input logic [1:0] m, input logic [7:0] d, input logic [7:0] oe,
                    input logic [15:0] len, input logic [15:0] dv);
    @(negedge clk);
    wr_valid = 1'b1; wr_mode = m; wr_data = d; wr_oe = oe; pulse_len = len; div = dv;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    repeat (GAP) @(negedge clk);
  endtask

  initial begin
    int nb;
    int bad;
    logic [7:0] exp8;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; wr_valid = 1'b0; wr_mode = 2'd0; wr_data = 8'h00;
    wr_oe = 8'h00; pulse_len = 16'd0; div = 16'd0;

    // Reset state and wr_ready release timing
    repeat (3) @(negedge clk);
    chk("rst_pad_t", pad_t, 8'hFF);
    chk("rst_pad_o", pad_o, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", wr_ready, 1'b0);
    rst_n = 1'b1;
    #1 chk("ready_before_clk", wr_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_clk", wr_ready, 1'b1);

    // STATIC, partial enable, held 100 cycles
    wr(2'd0, 8'hA5, 8'h0F, 16'd0, 16'd0);
    chk("static_pad_o", pad_o, 8'hA5);
    chk("static_pad_t", pad_t, 8'hF0);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (pad_o !== 8'hA5 || pad_t !== 8'hF0) bad++;
    end
    chk("static_hold_bad", bad, 0);

    // PULSE len 5 with a STATIC write held during busy
    @(negedge clk);
    wr_valid = 1'b1; wr_mode = 2'd1; wr_data = 8'hFF; wr_oe = 8'hFF; pulse_len = 16'd5; div = 16'd0;
    @(posedge clk);
    #1 wr_mode = 2'd0; wr_data = 8'h5A;
    @(negedge clk);
    repeat (GAP) @(negedge clk);
    chk("pulse_pad_o", pad_o, 8'hFF);
    chk("pulse_pad_t", pad_t, 8'h00);
    nb = 0; bad = 0;
    while (busy === 1'b1 && nb < 20) begin
      nb++;
      if (wr_ready !== 1'b0 || pad_o !== 8'hFF || done !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("pulse_busy_cycles", nb, 5);
    chk("pulse_during_bad", bad, 0);
    chk("pulse_done", done, 1'b1);
    chk("pulse_end_pad_o", pad_o, 8'h00);
    chk("pulse_done_ready", wr_ready, 1'b1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
    chk("done_single", done, 1'b0);
    repeat (GAP) @(negedge clk);
    chk("stalled_wr_pad_o", pad_o, 8'h5A);
    chk("stalled_wr_busy", busy, 1'b0);

    // WALK div=2: each position held 3 cycles, wraps 80 -> 01
    wr(2'd2, 8'hEE, 8'hFF, 16'd0, 16'd2);
    for (int i = 0; i < 27; i++) begin
      exp8 = 8'h01 << ((i / 3) % 8);
      chk($sformatf("walk_%0d", i), pad_o, exp8);
      if (i < 26) @(negedge clk);
    end
    wr(2'd0, 8'h77, 8'hFF, 16'd0, 16'd0);
    chk("walk_interrupt", pad_o, 8'h77);

    // TOGGLE div=0, then asynchronous reset mid-run
    wr(2'd3, 8'h3C, 8'hFF, 16'd0, 16'd0);
    chk("tog_0", pad_o, 8'h3C);
    @(negedge clk); chk("tog_1", pad_o, 8'hC3);
    @(negedge clk); chk("tog_2", pad_o, 8'h3C);
    @(negedge clk); chk("tog_3", pad_o, 8'hC3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pad_o", pad_o, 8'h00);
    chk("async_pad_t", pad_t, 8'hFF);
    chk("async_ready", wr_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during a PULSE aborts without a done strobe
    wr(2'd1, 8'h81, 8'hFF, 16'd10, 16'd0);
    chk("abort_busy_pre", busy, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_pad_o", pad_o, 8'h00);
    nb = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) nb++;
    end
    chk("abort_no_done", nb, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // pulse_len = 0 behaves as a single-cycle pulse
    wr(2'd1, 8'h42, 8'hFF, 16'd0, 16'd0);
    chk("len0_busy", busy, 1'b1);
    chk("len0_pad_o", pad_o, 8'h42);
    @(negedge clk);
    chk("len0_done", done, 1'b1);
    chk("len0_busy_end", busy, 1'b0);

    // All outputs disabled: sequence still runs internally
    wr(2'd2, 8'h00, 8'h00, 16'd0, 16'd0);
    chk("oe0_pad_t", pad_t, 8'hFF);
    chk("oe0_pad_o", pad_o, 8'h01);
    @(negedge clk);
    chk("oe0_step", pad_o, 8'h02);

    // Back-to-back STATIC writes: gap cycle only with break-before-make
    wr(2'd0, 8'h01, 8'hFF, 16'd0, 16'd0);
    chk("b2b_first", pad_o, 8'h01);
    wr_valid = 1'b1; wr_data = 8'h02;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    @(negedge clk);
`ifdef OBUF_BBM_EN
    chk("bbm_gap_pad_t", pad_t, 8'hFF);
    chk("bbm_gap_ready", wr_ready, 1'b0);
    @(negedge clk);
`endif
    chk("b2b_second", pad_o, 8'h02);
    chk("b2b_pad_t", pad_t, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
